// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake with
// instruction memory and loads the IF/ID pipeline register. A taken branch
// (PCSrc) redirects and flushes; Stall parks a fetched word in a hold buffer.
module fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              PCSrc,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic              Stall,
  output logic              IMemReq,
  output logic [ADDR_W-1:0] IMemAddr,
  input  logic              IMemAck,
  input  logic [31:0]       IMemRdata,
  output logic [31:0]       IF_ID_Instr,
  output logic [ADDR_W-1:0] IF_ID_PCPlus4,
  output logic              IF_ID_Valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] target;
  logic [31:0]       hold_instr;
  logic [ADDR_W-1:0] hold_pc4;
  logic              squash;

  // PC+4 wraps modulo 2^ADDR_W; branch targets are word aligned.
  assign pc_plus4 = pc + ADDR_W'(4);
  assign target   = {BranchTarget[ADDR_W-1:2], 2'b00};

  // Low target bits are deliberately ignored.
  logic unused_target_bits;
  assign unused_target_bits = ^BranchTarget[1:0];

  // Fetch FSM: PC, request outputs, squash flag, hold buffer and IF/ID.
  // NOTE: every register here, the hold buffer included, is reset and assigned
  // with non-blocking assignments so all state sees pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      IMemReq       <= 1'b0;
      IMemAddr      <= RESET_PC;
      IF_ID_Instr   <= '0;
      IF_ID_PCPlus4 <= '0;
      IF_ID_Valid   <= 1'b0;
      hold_instr    <= '0;
      hold_pc4      <= '0;
      squash        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state   <= REQ;
          IMemReq <= 1'b1;
          if (PCSrc) begin
            pc       <= target;
            IMemAddr <= target;
          end else begin
            IMemAddr <= pc;
          end
        end

        REQ: begin
          if (PCSrc) begin
            // Redirect wins over everything; an unacked request must still
            // complete with its old address, so its data is squashed later.
            IF_ID_Valid <= 1'b0;
            IF_ID_Instr <= '0;
            pc          <= target;
            if (IMemAck) begin
              IMemAddr <= target;
              squash   <= 1'b0;
            end else begin
              squash   <= 1'b1;
            end
          end else if (IMemAck) begin
            if (squash) begin
              // Wrong-path data: drop it and start fetching the target.
              squash   <= 1'b0;
              IMemAddr <= pc;
              if (!Stall) begin
                IF_ID_Valid <= 1'b0;
                IF_ID_Instr <= '0;
              end
            end else if (Stall) begin
              hold_instr <= IMemRdata;
              hold_pc4   <= pc_plus4;
              pc         <= pc_plus4;
              IMemAddr   <= pc_plus4;
              IMemReq    <= 1'b0;
              state      <= HOLD;
            end else begin
              IF_ID_Instr   <= IMemRdata;
              IF_ID_PCPlus4 <= pc_plus4;
              IF_ID_Valid   <= 1'b1;
              pc            <= pc_plus4;
              IMemAddr      <= pc_plus4;
            end
          end else if (!Stall) begin
            // Memory wait: decode sees a bubble.
            IF_ID_Valid <= 1'b0;
            IF_ID_Instr <= '0;
          end
        end

        HOLD: begin
          if (PCSrc) begin
            IF_ID_Valid <= 1'b0;
            IF_ID_Instr <= '0;
            pc          <= target;
            IMemAddr    <= target;
            IMemReq     <= 1'b1;
            state       <= REQ;
          end else if (!Stall) begin
            IF_ID_Instr   <= hold_instr;
            IF_ID_PCPlus4 <= hold_pc4;
            IF_ID_Valid   <= 1'b1;
            IMemAddr      <= pc;
            IMemReq       <= 1'b1;
            state         <= REQ;
          end
        end

        default: begin
          state   <= IDLE;
          IMemReq <= 1'b0;
        end
      endcase
    end
  end

endmodule
